// File: rtl/uart_tx_arb_if.sv
// Signal bundle between uart_tx_arb, its byte requesters and the UART transmitter.
// master = arbiter side; slave = requesters plus transmitter.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  // Handshake: byte i transfers on a rising clk edge where req_valid[i] && req_ready[i].
  // req_ready may depend combinationally on req_valid; req_valid/req_data/req_last must
  // never depend on req_ready, and a transfer is only counted while rst is low.
  logic [NUM_REQ-1:0]         req_valid;
  logic [8*NUM_REQ-1:0]       req_data;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ-1:0]         req_ready;
  logic [7:0]                 tx_data;
  logic                       tx_start;
  logic                       tx_busy;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                       active;
  logic                       err_timeout;
  logic [2:0]                 dbg_state;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, grant_id, active, err_timeout, dbg_state
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start, grant_id, active, err_timeout, dbg_state
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locking arbiter that feeds bytes from NUM_REQ requesters into one UART transmitter.
// dbg_state encoding: 0 ARB, 1 START, 2 WAIT_BUSY, 3 WAIT_DONE, 4 GAP.
module uart_tx_arb #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arb_if.master bus
);
  localparam int IDW     = $clog2(NUM_REQ);
  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_ARB       = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_lock_id;
  logic [IDW-1:0] r_grant_id;
  logic           r_lock;
  logic [7:0]     r_tx_data;
  logic           r_err_timeout;
  logic [CW-1:0]  r_cnt;
  logic           w_found;
  logic [IDW-1:0] w_sel;
  int             w_idx;
  logic           w_busy_to;
  logic           w_gap_done;
  logic           w_accept;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (32'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // Under lock only the packet owner is eligible; otherwise the lowest offset from rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    w_idx   = 0;
    if (r_lock) begin
      w_found = bus.req_valid[r_lock_id];
      w_sel   = r_lock_id;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
        if (bus.req_valid[w_idx]) begin
          w_found = 1'b1;
          w_sel   = IDW'(w_idx);
        end
      end
    end
  end

  assign w_busy_to  = (32'(r_cnt) + 32'd1 >= 32'(BUSY_TIMEOUT));
  assign w_gap_done = (32'(r_cnt) + 32'd1 >= 32'(GAP_CYCLES));
  assign w_accept   = (r_state == S_ARB) && w_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ARB;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ARB:       if (w_found) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.tx_busy)    w_state_nxt = S_WAIT_DONE;
        else if (w_busy_to) w_state_nxt = S_GAP;
      end
      S_WAIT_DONE: if (!bus.tx_busy) w_state_nxt = S_GAP;
      S_GAP:       if (w_gap_done) w_state_nxt = S_ARB;
      default:     w_state_nxt = S_ARB;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_accept && !rst) bus.req_ready[w_sel] = 1'b1;
    bus.tx_start  = (r_state == S_START);
    bus.active    = (r_state != S_ARB);
  end

  // The counter restarts on every state change, so it times both WAIT_BUSY and GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_tx_data     <= '0;
      r_grant_id    <= '0;
      r_rr_ptr      <= '0;
      r_lock        <= 1'b0;
      r_lock_id     <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == S_WAIT_BUSY || r_state == S_GAP)
        r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_tx_data  <= bus.req_data[8*w_sel +: 8];
        r_grant_id <= w_sel;
        r_lock     <= ~bus.req_last[w_sel];
        r_lock_id  <= w_sel;
        if (bus.req_last[w_sel]) r_rr_ptr <= next_id(w_sel);
      end
      if (r_state == S_WAIT_BUSY && !bus.tx_busy && w_busy_to) begin
        r_err_timeout <= 1'b1;
        r_lock        <= 1'b0;
        r_rr_ptr      <= next_id(r_grant_id);
      end
    end
  end

  assign bus.tx_data     = r_tx_data;
  assign bus.grant_id    = r_grant_id;
  assign bus.err_timeout = r_err_timeout;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: transmitter model, tx_start monitor and one task per scenario.
module tb_uart_tx_arb;
  localparam int BUSY_LEN = 4;

  logic clk;
  logic rst;
  logic tx_dead;
  int   busy_cnt;
  int   n_cmp;
  int   n_fail;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  uart_tx_arb_if #(.NUM_REQ(4)) ifc ();

  uart_tx_arb #(.NUM_REQ(4), .GAP_CYCLES(2), .BUSY_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: busy rises one cycle after tx_start and stays high BUSY_LEN cycles.
  initial begin
    ifc.tx_busy = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) busy_cnt = 0;
      ifc.tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (ifc.tx_start) begin
        got_q.push_back({8'(ifc.grant_id), ifc.tx_data});
        if (!tx_dead && !rst) busy_cnt = BUSY_LEN;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] d, input logic last);
    ifc.req_data[8*i +: 8] = d;
    ifc.req_last[i] = last;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.req_valid = '0;
    ifc.req_last = '0;
    ifc.req_data = '0;
    tx_dead = 1'b0;
    step();
    step();
    rst = 1'b0;
    got_q.delete();
    #1;
  endtask

  task automatic wait_got(input int n, input string name);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 300) begin
      step();
      cyc++;
    end
    n_cmp++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_wait: got %0d transfers, want %0d", name, got_q.size(), n);
    end
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (ifc.active !== 1'b0 && cyc < 100) begin
      step();
      cyc++;
    end
    n_cmp++;
    if (ifc.active !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: active=%b want 0", name, ifc.active);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_dead = 1'b0;
    ifc.req_valid = 4'b1111;
    ifc.req_last = 4'b1111;
    ifc.req_data = 32'h44332211;
    #3;
    n_cmp++; if (ifc.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", ifc.req_ready); end
    n_cmp++; if (ifc.dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", ifc.dbg_state); end
    n_cmp++; if (ifc.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", ifc.tx_start); end
    n_cmp++; if (ifc.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", ifc.tx_data); end
    n_cmp++; if (ifc.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", ifc.grant_id); end
    n_cmp++; if (ifc.active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", ifc.active); end
    n_cmp++; if (ifc.err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", ifc.err_timeout); end
  endtask

  task automatic test_single();
    int cyc;
    int gap_seen;
    do_reset();
    set_byte(0, 8'hA5, 1'b1);
    ifc.req_valid = 4'b0001;
    #1;
    n_cmp++; if (ifc.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", ifc.req_ready); end
    step();
    n_cmp++; if (ifc.tx_start !== 1'b1) begin n_fail++; $display("FAIL single_tx_start: got %b want 1", ifc.tx_start); end
    n_cmp++; if (ifc.tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data: got %h want a5", ifc.tx_data); end
    n_cmp++; if (ifc.dbg_state !== 3'd1) begin n_fail++; $display("FAIL single_state_start: got %0d want 1", ifc.dbg_state); end
    cyc = 1;
    gap_seen = 0;
    while (ifc.req_ready === 4'b0000 && cyc < 60) begin
      step();
      cyc++;
      if (cyc == 4) set_byte(0, 8'h5A, 1'b1);
      if (ifc.dbg_state === 3'd4) gap_seen++;
    end
    ifc.req_valid = 4'b0000;
    n_cmp++; if (cyc != 9) begin n_fail++; $display("FAIL single_regrant_latency: got %0d want 9", cyc); end
    n_cmp++; if (gap_seen != 2) begin n_fail++; $display("FAIL single_gap_cycles: got %0d want 2", gap_seen); end
    n_cmp++; if (ifc.tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold: got %h want a5", ifc.tx_data); end
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 16'h00A5) begin n_fail++; $display("FAIL single_sent: got %0d entries first %h want 00a5", got_q.size(), got_q[0]); end
    wait_idle("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    ifc.req_data = 32'h13121110;
    ifc.req_last = 4'b1111;
    ifc.req_valid = 4'b1111;
    wait_got(5, "rr");
    ifc.req_valid = 4'b0000;
    exp_q = '{16'h0010, 16'h0111, 16'h0212, 16'h0313, 16'h0010};
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    wait_idle("rr");
  endtask

  task automatic test_packet_lock();
    int cyc;
    int sent0;
    logic acc;
    do_reset();
    set_byte(0, 8'hB0, 1'b0);
    set_byte(1, 8'h21, 1'b1);
    ifc.req_valid = 4'b0011;
    sent0 = 0;
    cyc = 0;
    while (got_q.size() < 4 && cyc < 300) begin
      #1;
      acc = ifc.req_ready[0];
      step();
      cyc++;
      if (acc) begin
        sent0++;
        set_byte(0, 8'hB0 + 8'(sent0), sent0 == 2);
        if (sent0 == 3) ifc.req_valid[0] = 1'b0;
      end
    end
    ifc.req_valid = 4'b0000;
    exp_q = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h0121};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL lock_order[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_cmp++; if (sent0 != 3) begin n_fail++; $display("FAIL lock_req0_count: got %0d want 3", sent0); end
    wait_idle("lock");
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    tx_dead = 1'b1;
    set_byte(0, 8'h40, 1'b0);
    set_byte(1, 8'h41, 1'b1);
    ifc.req_valid = 4'b0011;
    #1;
    n_cmp++; if (ifc.req_ready !== 4'b0001) begin n_fail++; $display("FAIL to_first_ready: got %b want 0001", ifc.req_ready); end
    step();
    cyc = 1;
    while (ifc.err_timeout !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    n_cmp++; if (cyc != 18) begin n_fail++; $display("FAIL to_latency: got %0d want 18", cyc); end
    step();
    tx_dead = 1'b0;
    n_cmp++; if (ifc.err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", ifc.err_timeout); end
    step();
    n_cmp++; if (ifc.req_ready !== 4'b0010) begin n_fail++; $display("FAIL to_next_ready: got %b want 0010", ifc.req_ready); end
    wait_got(2, "to");
    ifc.req_valid = 4'b0000;
    n_cmp++; if (got_q[0] !== 16'h0040) begin n_fail++; $display("FAIL to_sent0: got %h want 0040", got_q[0]); end
    n_cmp++; if (got_q[1] !== 16'h0141) begin n_fail++; $display("FAIL to_sent1: got %h want 0141", got_q[1]); end
    wait_idle("to");
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    set_byte(1, 8'h77, 1'b1);
    set_byte(2, 8'h22, 1'b1);
    set_byte(3, 8'h33, 1'b1);
    ifc.req_valid = 4'b0010;
    cyc = 0;
    while (ifc.dbg_state !== 3'd3 && cyc < 40) begin
      step();
      cyc++;
    end
    n_cmp++; if (ifc.dbg_state !== 3'd3) begin n_fail++; $display("FAIL rm_reach_wait_done: got %0d want 3", ifc.dbg_state); end
    ifc.req_valid = 4'b1010;
    rst = 1'b1;
    #1;
    n_cmp++; if (ifc.dbg_state !== 3'd0) begin n_fail++; $display("FAIL rm_state: got %0d want 0", ifc.dbg_state); end
    n_cmp++; if (ifc.tx_data !== 8'h00) begin n_fail++; $display("FAIL rm_tx_data: got %h want 00", ifc.tx_data); end
    n_cmp++; if (ifc.grant_id !== 2'd0) begin n_fail++; $display("FAIL rm_grant: got %0d want 0", ifc.grant_id); end
    n_cmp++; if (ifc.active !== 1'b0) begin n_fail++; $display("FAIL rm_active: got %b want 0", ifc.active); end
    n_cmp++; if (ifc.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rm_ready: got %b want 0000", ifc.req_ready); end
    step();
    step();
    rst = 1'b0;
    got_q.delete();
    #1;
    n_cmp++; if (ifc.req_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_rr_restart: got %b want 0010", ifc.req_ready); end
    ifc.req_valid = 4'b0100;
    #1;
    n_cmp++; if (ifc.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rm_req2_ready: got %b want 0100", ifc.req_ready); end
    wait_got(1, "rm");
    ifc.req_valid = 4'b0000;
    n_cmp++; if (got_q[0] !== 16'h0222) begin n_fail++; $display("FAIL rm_sent: got %h want 0222", got_q[0]); end
    wait_idle("rm");
  endtask

  task automatic test_lock_stall();
    int bad;
    do_reset();
    set_byte(1, 8'h31, 1'b0);
    ifc.req_valid = 4'b0010;
    #1;
    n_cmp++; if (ifc.req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_first_ready: got %b want 0010", ifc.req_ready); end
    step();
    ifc.req_valid = 4'b1000;
    set_byte(3, 8'h33, 1'b1);
    bad = 0;
    repeat (20) begin
      step();
      if (ifc.req_ready !== 4'b0000) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL stall_no_ready: got %0d ready cycles want 0", bad); end
    n_cmp++; if (ifc.dbg_state !== 3'd0) begin n_fail++; $display("FAIL stall_parked: got state %0d want 0", ifc.dbg_state); end
    n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL stall_count: got %0d transfers want 1", got_q.size()); end
    set_byte(1, 8'h32, 1'b1);
    ifc.req_valid = 4'b1010;
    #1;
    n_cmp++; if (ifc.req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_resume: got %b want 0010", ifc.req_ready); end
    wait_got(3, "stall");
    ifc.req_valid = 4'b0000;
    exp_q = '{16'h0131, 16'h0132, 16'h0333};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_order[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    wait_idle("stall");
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_reset_mid();
    test_lock_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
